// File: rtl/axi_lite_txn_pkg.sv
// Shared types and constants for the AXI4-Lite transaction master and its bench.
package axi_lite_txn_pkg;

    typedef enum logic [1:0] {
        MODE_WR   = 2'd0,
        MODE_RD   = 2'd1,
        MODE_WRRD = 2'd2
    } mode_e;

    typedef enum logic [2:0] {
        StIdle,
        StWrIssue,
        StWrResp,
        StRdIssue,
        StRdResp,
        StFinish
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [15:0] ERR_IDX_NONE    = 16'hFFFF;
    localparam logic [15:0] READ_PHASE_FLAG = 16'h8000;

    // Encoding 3 is an alias of write-then-read.
    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd0:    return MODE_WR;
            2'd1:    return MODE_RD;
            default: return MODE_WRRD;
        endcase
    endfunction

endpackage

// File: rtl/axi_lite_txn_master.sv
// AXI4-Lite traffic master: issues NUM_TXN writes and/or reads one at a time,
// checks responses and read data, and reports error count, first failure and timeouts.
module axi_lite_txn_master
    import axi_lite_txn_pkg::*;
#(
    parameter int unsigned              ADDR_WIDTH     = 32,
    parameter int unsigned              DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR      = 'h4000_0000,
    parameter int unsigned              ADDR_STRIDE    = DATA_WIDTH / 8,
    parameter int unsigned              NUM_TXN        = 16,
    parameter logic [DATA_WIDTH-1:0]    START_DATA     = 'hAA00_0000,
    parameter int unsigned              TIMEOUT_CYCLES = 1024
) (
    input  logic                      M_AXI_ACLK,
    input  logic                      M_AXI_ARESET,
    input  logic                      start,
    input  logic [1:0]                mode,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [15:0]               err_count,
    output logic [15:0]               first_err_idx,
    output logic                      timeout,
    output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                M_AXI_AWPROT,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                M_AXI_ARPROT,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);

    localparam logic [15:0] LastIdx = 16'(NUM_TXN - 1);
    localparam logic [31:0] TmoLast = 32'(TIMEOUT_CYCLES - 1);

    state_e        state_q, state_d;
    mode_e         mode_q, mode_d;
    logic [15:0]   index_q, index_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic [31:0]   tmo_cnt_q, tmo_cnt_d;
    logic          error_q, error_d;
    logic [15:0]   err_count_q, err_count_d;
    logic [15:0]   first_err_q, first_err_d;
    logic          timeout_q, timeout_d;

    logic [ADDR_WIDTH-1:0] txn_addr;
    logic [DATA_WIDTH-1:0] txn_data;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs;
    logic fail, tmo_hit, tmo_expire, last_txn, rd_phase;

    // Address wraps modulo 2^ADDR_WIDTH by construction of the cast widths.
    assign txn_addr = BASE_ADDR + ADDR_WIDTH'(index_q) * ADDR_WIDTH'(ADDR_STRIDE);
    assign txn_data = START_DATA + DATA_WIDTH'(index_q);

    assign aw_hs      = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_hs       = M_AXI_WVALID & M_AXI_WREADY;
    assign b_hs       = M_AXI_BVALID & M_AXI_BREADY;
    assign ar_hs      = M_AXI_ARVALID & M_AXI_ARREADY;
    assign r_hs       = M_AXI_RVALID & M_AXI_RREADY;
    assign any_hs     = aw_hs | w_hs | b_hs | ar_hs | r_hs;
    assign tmo_expire = (tmo_cnt_q == TmoLast);
    assign last_txn   = (index_q == LastIdx);
    assign rd_phase   = (state_q == StRdIssue) || (state_q == StRdResp);

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state_q     <= StIdle;
            mode_q      <= MODE_WR;
            index_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            tmo_cnt_q   <= '0;
            error_q     <= 1'b0;
            err_count_q <= '0;
            first_err_q <= ERR_IDX_NONE;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            index_q     <= index_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            tmo_cnt_q   <= tmo_cnt_d;
            error_q     <= error_d;
            err_count_q <= err_count_d;
            first_err_q <= first_err_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        index_d     = index_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        error_d     = error_q;
        err_count_d = err_count_q;
        first_err_d = first_err_q;
        timeout_d   = timeout_q;
        fail        = 1'b0;
        tmo_hit     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d      = decode_mode(mode);
                    index_d     = '0;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    error_d     = 1'b0;
                    err_count_d = '0;
                    first_err_d = ERR_IDX_NONE;
                    timeout_d   = 1'b0;
                    state_d     = (decode_mode(mode) == MODE_RD) ? StRdIssue : StWrIssue;
                end
            end
            StWrIssue: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) begin
                    state_d = StWrResp;
                end else if (tmo_expire && !aw_hs && !w_hs) begin
                    tmo_hit = 1'b1;
                end
            end
            StWrResp: begin
                if (b_hs) begin
                    fail = (M_AXI_BRESP != RESP_OKAY);
                    if (last_txn) begin
                        index_d = '0;
                        state_d = (mode_q == MODE_WRRD) ? StRdIssue : StFinish;
                    end else begin
                        index_d   = index_q + 16'd1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = StWrIssue;
                    end
                end else if (tmo_expire) begin
                    tmo_hit = 1'b1;
                end
            end
            StRdIssue: begin
                if (ar_hs) begin
                    state_d = StRdResp;
                end else if (tmo_expire) begin
                    tmo_hit = 1'b1;
                end
            end
            StRdResp: begin
                if (r_hs) begin
                    fail = (M_AXI_RRESP != RESP_OKAY) ||
                           ((mode_q == MODE_WRRD) && (M_AXI_RDATA != txn_data));
                    if (last_txn) begin
                        state_d = StFinish;
                    end else begin
                        index_d = index_q + 16'd1;
                        state_d = StRdIssue;
                    end
                end else if (tmo_expire) begin
                    tmo_hit = 1'b1;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        if (fail || tmo_hit) begin
            error_d = 1'b1;
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
            if (first_err_q == ERR_IDX_NONE) begin
                first_err_d = rd_phase ? (index_q | READ_PHASE_FLAG) : index_q;
            end
        end
        if (tmo_hit) begin
            timeout_d = 1'b1;
            state_d   = StFinish;
        end

        // Per-handshake budget: restarts on every state entry and every completed handshake.
        if (state_q == StIdle || state_d != state_q || any_hs) begin
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 32'd1;
        end
    end

    always_comb begin
        M_AXI_AWADDR  = txn_addr;
        M_AXI_AWPROT  = 3'b000;
        M_AXI_AWVALID = (state_q == StWrIssue) && !aw_done_q;
        M_AXI_WDATA   = txn_data;
        M_AXI_WSTRB   = '1;
        M_AXI_WVALID  = (state_q == StWrIssue) && !w_done_q;
        M_AXI_BREADY  = (state_q == StWrResp);
        M_AXI_ARADDR  = txn_addr;
        M_AXI_ARPROT  = 3'b000;
        M_AXI_ARVALID = (state_q == StRdIssue);
        M_AXI_RREADY  = (state_q == StRdResp);
        busy          = (state_q != StIdle) && (state_q != StFinish);
        done          = (state_q == StFinish);
        error         = error_q;
        err_count     = err_count_q;
        first_err_idx = first_err_q;
        timeout       = timeout_q;
    end

endmodule

// File: tb/tb_axi_lite_txn_master.sv
// Bench: behavioural memory slave with stall/fault knobs and a scoreboard of expected beats.
module tb_axi_lite_txn_master;
    import axi_lite_txn_pkg::*;

    localparam int unsigned NTXN = 16;
    localparam int unsigned TMO  = 64;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] SEED = 32'hAA00_0000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [1:0] mode = 2'd0;
    logic busy, done, error, timeout;
    logic [15:0] err_count, first_err_idx;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0] awprot, arprot;
    logic [3:0] wstrb;
    logic awvalid, awready, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rvalid, rready;
    logic [1:0] bresp, rresp;

    always #5 clk = ~clk;

    axi_lite_txn_master #(
        .TIMEOUT_CYCLES(TMO)
    ) u_dut (
        .M_AXI_ACLK   (clk),
        .M_AXI_ARESET (rst),
        .start        (start),
        .mode         (mode),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_count    (err_count),
        .first_err_idx(first_err_idx),
        .timeout      (timeout),
        .M_AXI_AWADDR (awaddr),
        .M_AXI_AWPROT (awprot),
        .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready),
        .M_AXI_WDATA  (wdata),
        .M_AXI_WSTRB  (wstrb),
        .M_AXI_WVALID (wvalid),
        .M_AXI_WREADY (wready),
        .M_AXI_BRESP  (bresp),
        .M_AXI_BVALID (bvalid),
        .M_AXI_BREADY (bready),
        .M_AXI_ARADDR (araddr),
        .M_AXI_ARPROT (arprot),
        .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_RDATA  (rdata),
        .M_AXI_RRESP  (rresp),
        .M_AXI_RVALID (rvalid),
        .M_AXI_RREADY (rready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Slave knobs
    int aw_stall = 0;
    int w_stall = 0;
    logic ar_block = 1'b0;
    int slverr_idx = -1;
    int corrupt_idx = -1;

    logic aw_got, w_got;
    logic [31:0] aw_a, w_d;
    int aw_cnt, w_cnt, wr_cnt, rd_cnt;
    logic [31:0] mem [0:63];
    logic wr_fire;
    logic [31:0] wr_addr, wr_data;

    assign awready = awvalid && !aw_got && (aw_cnt >= aw_stall);
    assign wready  = wvalid && !w_got && (w_cnt >= w_stall);
    assign arready = arvalid && !ar_block && !rvalid;
    assign wr_fire = !bvalid && (aw_got || (awvalid && awready)) && (w_got || (wvalid && wready));
    assign wr_addr = aw_got ? aw_a : awaddr;
    assign wr_data = w_got ? w_d : wdata;

    always @(posedge clk) begin
        if (rst) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            aw_cnt <= 0;
            w_cnt  <= 0;
            wr_cnt <= 0;
            rd_cnt <= 0;
            bvalid <= 1'b0;
            rvalid <= 1'b0;
            bresp  <= RESP_OKAY;
            rresp  <= RESP_OKAY;
        end else begin
            if (!busy) begin
                wr_cnt <= 0;
                rd_cnt <= 0;
            end
            if (awvalid && !awready) aw_cnt <= aw_cnt + 1;
            if (awvalid && awready) begin
                aw_got <= 1'b1;
                aw_a   <= awaddr;
                aw_cnt <= 0;
            end
            if (wvalid && !wready) w_cnt <= w_cnt + 1;
            if (wvalid && wready) begin
                w_got <= 1'b1;
                w_d   <= wdata;
                w_cnt <= 0;
            end
            if (wr_fire) begin
                mem[wr_addr[7:2]] <= wr_data;
                bvalid <= 1'b1;
                bresp  <= (wr_cnt == slverr_idx) ? RESP_SLVERR : RESP_OKAY;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                wr_cnt <= wr_cnt + 1;
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rresp  <= RESP_OKAY;
                rdata  <= mem[araddr[7:2]] ^ ((rd_cnt == corrupt_idx) ? 32'd1 : 32'd0);
                rd_cnt <= rd_cnt + 1;
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    // Scoreboard and handshake statistics, sampled on the falling edge.
    wr_exp_t exp_wr[$];
    logic [31:0] exp_rd[$];
    int aw_lens[$];
    int w_lens[$];
    int n_b = 0, n_r = 0, n_done = 0;
    int aw_run = 0, w_run = 0, ar_run = 0, ar_len_last = 0, aw_unstable = 0;
    logic aw_pend = 1'b0;
    logic [31:0] aw_prev = '0;

    initial begin
        wr_exp_t e;
        logic [31:0] ea;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (wr_fire) begin
                    if (exp_wr.size() == 0) begin
                        check_eq("wr_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = exp_wr.pop_front();
                        check_eq("wr_addr", 64'(wr_addr), 64'(e.addr));
                        check_eq("wr_data", 64'(wr_data), 64'(e.data));
                    end
                end
                if (arvalid && arready) begin
                    if (exp_rd.size() == 0) begin
                        check_eq("rd_unexpected", 64'd1, 64'd0);
                    end else begin
                        ea = exp_rd.pop_front();
                        check_eq("rd_addr", 64'(araddr), 64'(ea));
                    end
                end
                if (bvalid && bready) n_b++;
                if (rvalid && rready) n_r++;
                if (done) n_done++;
                if (aw_pend && awvalid && awaddr != aw_prev) aw_unstable++;
                aw_pend = awvalid && !awready;
                aw_prev = awaddr;
                if (awvalid) aw_run++;
                if (awvalid && awready) begin
                    aw_lens.push_back(aw_run);
                    aw_run = 0;
                end
                if (wvalid) w_run++;
                if (wvalid && wready) begin
                    w_lens.push_back(w_run);
                    w_run = 0;
                end
                if (arvalid) begin
                    ar_run++;
                    if (arready) ar_run = 0;
                end else if (ar_run != 0) begin
                    ar_len_last = ar_run;
                    ar_run = 0;
                end
            end
        end
    end

    task automatic push_expect(input logic [1:0] m);
        for (int i = 0; i < int'(NTXN); i++) begin
            if (m != 2'd1) exp_wr.push_back(wr_exp_t'{addr: BASE + 32'(i * 4), data: SEED + 32'(i)});
            if (m != 2'd0) exp_rd.push_back(BASE + 32'(i * 4));
        end
    endtask

    task automatic do_start(input logic [1:0] m);
        push_expect(m);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("done_seen", 64'(seen), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_done"}, 64'(done), 64'd0);
        check_eq({tag, "_error"}, 64'(error), 64'd0);
        check_eq({tag, "_errcnt"}, 64'(err_count), 64'd0);
        check_eq({tag, "_first"}, 64'(first_err_idx), 64'hFFFF);
        check_eq({tag, "_timeout"}, 64'(timeout), 64'd0);
        check_eq({tag, "_valids"}, 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
    endtask

    task automatic check_clean(input string tag, input int nb0, input int nr0, input int reads);
        check_eq({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check_eq({tag, "_error"}, 64'(error), 64'd0);
        check_eq({tag, "_errcnt"}, 64'(err_count), 64'd0);
        check_eq({tag, "_first"}, 64'(first_err_idx), 64'hFFFF);
        check_eq({tag, "_timeout"}, 64'(timeout), 64'd0);
        check_eq({tag, "_nb"}, 64'(n_b - nb0), 64'(NTXN));
        check_eq({tag, "_nr"}, 64'(n_r - nr0), 64'(reads));
        check_eq({tag, "_wrq_empty"}, 64'(exp_wr.size()), 64'd0);
        check_eq({tag, "_rdq_empty"}, 64'(exp_rd.size()), 64'd0);
    endtask

    initial begin
        int nb0, nr0, nd0;
        logic found;
        for (int i = 0; i < 64; i++) mem[i] = '0;

        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Clean write-then-read run.
        nb0 = n_b; nr0 = n_r;
        do_start(2'd2);
        check_eq("busy_after_start", 64'(busy), 64'd1);
        wait_done();
        check_clean("wrrd", nb0, nr0, NTXN);
        @(negedge clk);
        check_eq("done_one_cycle", 64'(done), 64'd0);

        // start while busy and on the done cycle must both be ignored.
        nd0 = n_done;
        do_start(2'd2);
        repeat (10) @(negedge clk);
        mode = 2'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("ign_busy_after_done", 64'(busy), 64'd0);
        repeat (10) @(negedge clk);
        check_eq("ign_run_count", 64'(n_done - nd0), 64'd1);
        check_eq("ign_still_idle", 64'(busy), 64'd0);
        check_eq("ign_error", 64'(error), 64'd0);

        // AWREADY held off 5 cycles per write; W accepted immediately.
        aw_stall = 5;
        aw_lens.delete(); w_lens.delete(); aw_unstable = 0;
        nb0 = n_b; nr0 = n_r;
        do_start(2'd0);
        wait_done();
        check_clean("stall", nb0, nr0, 0);
        check_eq("stall_aw_count", 64'(aw_lens.size()), 64'(NTXN));
        for (int i = 0; i < aw_lens.size(); i++) begin
            check_eq("stall_aw_len", 64'(aw_lens[i]), 64'd6);
            check_eq("stall_w_len", 64'(w_lens[i]), 64'd1);
        end
        check_eq("stall_aw_stable", 64'(aw_unstable), 64'd0);
        aw_stall = 0;
        @(negedge clk);

        // SLVERR on write 3, corrupted data on read 7; mode 3 behaves as mode 2.
        slverr_idx = 3; corrupt_idx = 7;
        nb0 = n_b; nr0 = n_r;
        do_start(2'd3);
        wait_done();
        check_eq("err_error", 64'(error), 64'd1);
        check_eq("err_count", 64'(err_count), 64'd2);
        check_eq("err_first", 64'(first_err_idx), 64'h0003);
        check_eq("err_timeout", 64'(timeout), 64'd0);
        check_eq("err_nb", 64'(n_b - nb0), 64'(NTXN));
        check_eq("err_nr", 64'(n_r - nr0), 64'(NTXN));
        slverr_idx = -1; corrupt_idx = -1;
        @(negedge clk);

        // ARREADY never arrives: read-only run must time out after TMO cycles.
        ar_block = 1'b1;
        do_start(2'd1);
        wait_done();
        check_eq("tmo_timeout", 64'(timeout), 64'd1);
        check_eq("tmo_error", 64'(error), 64'd1);
        check_eq("tmo_errcnt", 64'(err_count), 64'd1);
        check_eq("tmo_first", 64'(first_err_idx), 64'h8000);
        check_eq("tmo_arvalid_drop", 64'(arvalid), 64'd0);
        check_eq("tmo_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check_eq("tmo_ar_len", 64'(ar_len_last), 64'(TMO));
        check_eq("tmo_done_pulse", 64'(done), 64'd0);
        ar_block = 1'b0;
        exp_rd.delete();

        // Reset during the B phase of index 5 aborts without done.
        nb0 = n_b;
        do_start(2'd2);
        found = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (bready && (n_b - nb0 == 5)) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("rst_reach_idx5", 64'(found), 64'd1);
        nd0 = n_done;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        exp_wr.delete(); exp_rd.delete();
        repeat (5) @(negedge clk);
        check_eq("midrst_no_done", 64'(n_done - nd0), 64'd0);

        nb0 = n_b; nr0 = n_r;
        do_start(2'd2);
        wait_done();
        check_clean("post_rst", nb0, nr0, NTXN);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
